// File: rtl/ram_wrapper_pkg.sv
// ============================================================================
// ram_wrapper_pkg : shared widths and write-enable encoding for ram_wrapper
// Revision: 1.0
// ============================================================================
`default_nettype none

package ram_wrapper_pkg;

    localparam int DATA_W     = 32;
    localparam int RAM_ADDR_W = 20;
    localparam int SEL_W      = 4;

    typedef enum logic {
        WriteDisable = 1'b0,
        WriteEnable  = 1'b1
    } we_e;

endpackage

`default_nettype wire

// File: rtl/ram_wrapper_bus.sv
// ============================================================================
// ram_wrapper_bus : tri-state driver for the shared 32-bit SRAM data bus
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_wrapper_bus
    import ram_wrapper_pkg::*;
(
    input  logic              drive_en_i,
    input  logic [DATA_W-1:0] wdata_i,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] rdata_o
);

    assign ram_data = drive_en_i ? wdata_i : {DATA_W{1'bz}};
    assign rdata_o  = ram_data;

endmodule

`default_nettype wire

// File: rtl/ram_wrapper.sv
// ============================================================================
// ram_wrapper : single-cycle CPU-to-async-SRAM bridge (two 16-bit chips).
// Option macro: RAM_WE_HALF_CYCLE_EN (ram_we_n low only while clk is low).
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_wrapper
    import ram_wrapper_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           addr_i,
    input  logic                  ce_i,
    input  logic                  we_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic [SEL_W-1:0]      sel_i,
    output logic [DATA_W-1:0]     data_o,
    inout  wire  [DATA_W-1:0]     ram_data,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [SEL_W-1:0]      ram_be_n,
    output logic                  ram_ce_n,
    output logic                  ram_oe_n,
    output logic                  ram_we_n
);

    logic              en_q;
    logic              en_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] w_rdata;
    logic              w_access;
    logic              w_wr;
    logic              w_rd;
    we_e               w_we;
    logic              w_unused_addr;

    assign w_we          = we_e'(we_i);
    assign w_unused_addr = ^{addr_i[31:22], addr_i[1:0]};

    always_comb begin
        w_access = en_q & ce_i;
        w_wr     = w_access && (w_we == WriteEnable);
        w_rd     = w_access && (w_we == WriteDisable);
        en_d     = 1'b1;
        data_d   = data_q;
        if (w_rd) begin
            data_d = w_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q   <= 1'b0;
            data_q <= '0;
        end else begin
            en_q   <= en_d;
            data_q <= data_d;
        end
    end

    assign data_o   = data_q;
    assign ram_addr = addr_i[RAM_ADDR_W+1:2];
    assign ram_ce_n = ~w_access;
    assign ram_oe_n = ~w_rd;

    always_comb begin
        ram_be_n = '1;
        if (w_wr) begin
            ram_be_n = ~sel_i;
        end else if (w_rd) begin
            ram_be_n = '0;
        end
    end

`ifdef RAM_WE_HALF_CYCLE_EN
    // Pulse only in the low phase so address/data settle before and after it.
    assign ram_we_n = ~(w_wr & ~clk);
`else
    assign ram_we_n = ~w_wr;
`endif

    ram_wrapper_bus u_bus (
        .drive_en_i (w_wr),
        .wdata_i    (data_i),
        .ram_data   (ram_data),
        .rdata_o    (w_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_ram_wrapper.sv
// ============================================================================
// tb_ram_wrapper : scoreboard bench for ram_wrapper with a behavioural SRAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram_wrapper;
    import ram_wrapper_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr_i = '0;
    logic        ce_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] data_i = '0;
    logic [3:0]  sel_i = '0;
    logic [31:0] data_o;
    wire  [31:0] ram_data;
    logic [19:0] ram_addr;
    logic [3:0]  ram_be_n;
    logic        ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;

    int tests = 0;
    int fails = 0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_wrapper dut (
        .clk      (clk),
        .rst      (rst),
        .addr_i   (addr_i),
        .ce_i     (ce_i),
        .we_i     (we_i),
        .data_i   (data_i),
        .sel_i    (sel_i),
        .data_o   (data_o),
        .ram_data (ram_data),
        .ram_addr (ram_addr),
        .ram_be_n (ram_be_n),
        .ram_ce_n (ram_ce_n),
        .ram_oe_n (ram_oe_n),
        .ram_we_n (ram_we_n)
    );

    // Asynchronous SRAM chips (low chip [15:0], high chip [31:16]).
    logic [31:0] sram [0:(1<<20)-1];
    wire sram_rd = !ram_ce_n && !ram_oe_n && ram_we_n;
    assign ram_data = sram_rd ? sram[ram_addr] : 32'hzzzz_zzzz;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] en);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (en[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(negedge clk) begin
        #3;
        if (!ram_ce_n && !ram_we_n) sram[ram_addr] <= merge(sram[ram_addr], ram_data, ~ram_be_n);
    end

    // Reference model: word-addressed memory plus last value read.
    logic [31:0] ref_mem [bit [19:0]];
    logic [31:0] model_dout = '0;

    function automatic logic [31:0] ref_rd(input logic [19:0] i);
        if (ref_mem.exists(i)) return ref_mem[i];
        return 32'h0;
    endfunction

    typedef struct {
        int unsigned cyc;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each pushed entry is due at the first edge after its cycle started.
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            #2;
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                chk("data_o", data_o, e.exp);
            end
        end
    end

    task automatic op(input logic ce, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
        logic        wr;
        logic        rd;
        logic [19:0] idx;
        sb_t         e;
        @(posedge clk);
        #1;
        ce_i = ce; we_i = we; addr_i = a; data_i = d; sel_i = s;
        wr  = ce && we;
        rd  = ce && !we;
        idx = 20'((a >> 2) & 32'hF_FFFF);
        if (wr) ref_mem[idx] = merge(ref_rd(idx), d, s);
        if (rd) model_dout = ref_rd(idx);
        e.cyc = cyc;
        e.exp = model_dout;
        sbq.push_back(e);
        #1;
        chk("ram_addr", {12'h0, ram_addr}, {12'h0, idx});
        chk("ram_ce_n", {31'h0, ram_ce_n}, {31'h0, !ce});
        chk("ram_oe_n", {31'h0, ram_oe_n}, {31'h0, !rd});
        chk("ram_be_n", {28'h0, ram_be_n}, {28'h0, wr ? ~s : (rd ? 4'h0 : 4'hF)});
        chk("bus_drive", {31'h0, dut.u_bus.drive_en_i}, {31'h0, wr});
`ifdef RAM_WE_HALF_CYCLE_EN
        chk("we_n_clk_hi", {31'h0, ram_we_n}, 32'h1);
`else
        chk("we_n_clk_hi", {31'h0, ram_we_n}, {31'h0, !wr});
`endif
        @(negedge clk);
        #1;
        chk("we_n_clk_lo", {31'h0, ram_we_n}, {31'h0, !wr});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 10) begin
            @(posedge clk);
            #3;
            n++;
        end
        if (sbq.size() > 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    // Reset with an attempted write held on the inputs to prove it is blocked.
    task automatic do_reset(input int cycles);
        drain();
        @(posedge clk);
        #1;
        rst = 1'b0; ce_i = 1'b1; we_i = 1'b1; sel_i = 4'hF; data_i = 32'hCAFE_F00D;
        repeat (cycles) @(posedge clk);
        #1;
        chk("rst_data_o", data_o, 32'h0);
        chk("rst_ce_n", {31'h0, ram_ce_n}, 32'h1);
        chk("rst_oe_n", {31'h0, ram_oe_n}, 32'h1);
        chk("rst_be_n", {28'h0, ram_be_n}, 32'hF);
        chk("rst_bus", {31'h0, dut.u_bus.drive_en_i}, 32'h0);
        @(negedge clk);
        #1;
        chk("rst_we_n", {31'h0, ram_we_n}, 32'h1);
        model_dout = '0;
        @(posedge clk);
        #1;
        rst = 1'b1; ce_i = 1'b0;
    endtask

    initial begin
        foreach (sram[i]) sram[i] = '0;
        do_reset(2);

        op(1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF);
        op(1, 0, 32'hFFFF_FFFC, 32'h0, 4'h0);

        for (int i = 0; i < 4; i++) op(1, 1, 32'(i * 4), 32'(i), 4'hF);
        for (int i = 3; i >= 0; i--) op(1, 0, 32'(i * 4), 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) op(1, 1, 32'(i * 4), 32'(i), 4'hF);
        for (int i = 0; i < 4; i++) op(1, 0, 32'(i * 4), 32'h0, 4'h0);

        op(1, 1, 32'h1000, 32'h2333, 4'hF);
        op(1, 0, 32'h1000, 32'h0, 4'h0);

        op(1, 1, 32'h0, 32'h0, 4'hF);
        op(1, 1, 32'h0, 32'hAABB_CCDD, 4'b0001);
        op(1, 0, 32'h0, 32'h0, 4'h0);

        for (int i = 0; i < 3; i++) op(0, 1, 32'h0, 32'hDEAD_BEEF, 4'hF);
        op(1, 0, 32'h0, 32'h0, 4'h0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFC0_0003) | (32'($urandom_range(0, 31)) << 2);
            op(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0, 1'($urandom), a, $urandom,
               4'($urandom_range(0, 15)));
        end

        do_reset(1);
        for (int i = 0; i < 4; i++) op(1, 0, 32'(i * 4), 32'h0, 4'h0);
        op(1, 0, 32'h1000, 32'h0, 4'h0);

        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
